store_buffer: RTL and testbench
===============================

# store_buffer

Posted write buffer between the store byte-lane formatter and the data-memory write port. It accepts formatted stores (word-aligned address, lane-positioned data, byte enables) from the memory stage and queues them in a small FIFO. It drains them to data memory over a req/ack handshake, so the pipeline does not stall on slow memory writes unless the buffer is full. Optionally, it forwards buffered bytes to loads that hit a pending store.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2
- AW, 32, address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store offered by memory stage
- st_ready  out  1  buffer can accept (not full)
- st_addr  in  AW  store byte address; bits [1:0] ignored
- st_data  in  32  lane-positioned store data from the formatter
- st_be  in  4  byte enables; 4'b0000 encodes a full-word store
- mem_req  out  1  head entry valid on memory port
- mem_addr  out  AW  head address, bits [1:0] forced 0
- mem_wdata  out  32  head data
- mem_be  out  4  head byte enables, never 4'b0000 while mem_req=1
- mem_ack  in  1  memory accepted head this cycle
- ld_addr  in  AW  load address for forwarding lookup
- ld_hit  out  1  at least one buffered byte covers ld_addr word
- ld_data  out  32  forwarded bytes (merged)
- ld_be  out  4  which bytes of ld_data are valid
- empty  out  1  no entries buffered
- full  out  1  DEPTH entries buffered

## Operation
- Storage: circular FIFO of DEPTH entries {addr[AW-1:2], data[31:0], be[3:0]}. It uses wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits, 0..DEPTH).
- Enqueue when st_valid && st_ready. If st_be==4'b0000, store be=4'b1111; otherwise store st_be unchanged. Enqueue increments wr_ptr.
- st_ready = !full. The ready decision uses the current count only. No same-cycle pass-through: if full and mem_ack=1 in the same cycle, the offered store is still refused.
- Drain: mem_req = !empty. mem_addr, mem_wdata and mem_be come from the entry at rd_ptr and stay stable while mem_req && !mem_ack. A pop happens when mem_req && mem_ack and increments rd_ptr. mem_ack while empty is ignored.
- Simultaneous enqueue and pop: count is unchanged, and both pointers advance.
- Count never exceeds DEPTH and never goes below 0. Pointer wrap from DEPTH-1 to 0 needs no special handling.
- Writes drain in program order. No coalescing of stores to the same word.

## Timing
- Reset (rst_n=0, asynchronous) sets count=0 and both pointers to 0, which gives empty=1, full=0, st_ready=1 and mem_req=0. It also forces mem_addr, mem_wdata, mem_be, ld_hit, ld_data and ld_be to 0. Reset during a pending memory transaction discards all entries, and mem_req drops immediately.
- Enqueue into an empty buffer at edge N raises mem_req after edge N, so the earliest ack is in cycle N+1.
- Ack at edge M presents the next entry after edge M. With back-to-back acks, one store retires per cycle.
- full and empty are registered-state decodes and carry no combinational path from st_valid or mem_ack.
- Forwarding outputs are combinational from ld_addr and buffer contents, valid in the same cycle. A store enqueued at the current edge is visible only after that edge.

## Configuration
- STORE_BUFFER_FWD_EN defined:
  - All valid entries are compared on addr[AW-1:2] == ld_addr[AW-1:2].
  - Per byte lane, the youngest matching entry with that be bit set supplies ld_data for that lane.
  - ld_be is the OR of the be bits of all matching entries. ld_hit = |ld_be. Lanes with no match read 0.
- STORE_BUFFER_FWD_EN undefined:
  - No comparators are built.
  - ld_hit, ld_data and ld_be are tied to 0. The ports remain.
  - The load path must instead wait for empty=1 before reading memory.

## Structure
- Shared package store_buffer_pkg:
  - entry struct/field widths (BE_W=4, DATA_W=32)
  - constant BE_FULL_WORD=4'b1111
  - constant BE_WORD_CODE=4'b0000 (upstream full-word encoding)
- Sub-module store_buffer_fwd: the age-ordered per-byte match/merge, instantiated only under STORE_BUFFER_FWD_EN. The top level holds the FIFO, pointers and handshake.

## Test plan
- Reset then idle: after reset, check st_ready=1, empty=1, mem_req=0 and all data outputs 0. Hold mem_ack=1 while empty: count stays 0.
- Single byte store: st_addr=0x0000_1002, st_data=0x00AB_0000, st_be=4'b0100. The next cycle shows mem_req=1, mem_addr=0x0000_1000, mem_be=4'b0100. Hold mem_ack=0 for 3 cycles and confirm the outputs stay stable. Then ack, and empty=1 follows.
- Word store encoding: st_be=4'b0000, st_data=0xDEAD_BEEF. The memory port shows mem_be=4'b1111 and mem_wdata=0xDEAD_BEEF.
- Fill and wrap (DEPTH=4):
  - Enqueue 4 stores with mem_ack=0, giving full=1 and st_ready=0.
  - Offer a 5th store with mem_ack=1 in the same cycle: it is refused and count=3.
  - Enqueue 2 more across the wrap. They drain in exact issue order.
- Forwarding (macro defined):
  - Buffer {0x100, 0x0000_0011, 4'b0001}, then {0x100, 0x0000_2200, 4'b0010}, then {0x100, 0x0000_0033, 4'b0001}.
  - Set ld_addr=0x103: expect ld_hit=1, ld_be=4'b0011, ld_data=0x0000_2233.
  - Set ld_addr=0x104: expect ld_hit=0. With the macro undefined, ld_hit=0 always.
- Reset mid-drain: with 3 entries queued and mem_req=1, pulse rst_n low between edges. mem_req drops immediately, and after release empty=1 with no further mem_req.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer and its forwarding network.
package store_buffer_pkg;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  // Byte-enable pattern written to memory for a full-word store
  localparam logic [BE_W-1:0] BE_FULL_WORD = 4'b1111;
  // Upstream formatter encodes a full-word store as all-zero enables
  localparam logic [BE_W-1:0] BE_WORD_CODE = 4'b0000;

  // Data half of a buffered entry; the word address is kept alongside
  // because its width follows the AW parameter of the instantiating module.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } sb_payload_t;

  // Converts the upstream full-word code into explicit lane enables so the
  // memory port never sees an all-zero mask.
  function automatic logic [BE_W-1:0] normalize_be(input logic [BE_W-1:0] be);
    return (be == BE_WORD_CODE) ? BE_FULL_WORD : be;
  endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// Age-ordered store-to-load forwarding network. Entry 0 is the oldest buffered
// store; for every byte lane the youngest matching entry with that lane enabled
// supplies the forwarded byte. Built only when STORE_BUFFER_FWD_EN is defined.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic [AW-3:0]     i_addr  [DEPTH],
  input  sb_payload_t       i_entry [DEPTH],
  input  logic [DEPTH-1:0]  i_valid,
  input  logic [AW-1:0]     i_ld_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data,
  output logic [BE_W-1:0]   o_be
);

  logic w_unused_ld_lo;
  assign w_unused_ld_lo = ^i_ld_addr[1:0];

  // Walk entries oldest to youngest so later matches overwrite earlier lanes
  always_comb begin
    o_data = '0;
    o_be   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_valid[k] && (i_addr[k] == i_ld_addr[AW-1:2])) begin
        o_be = o_be | i_entry[k].be;
        for (int l = 0; l < BE_W; l++) begin
          if (i_entry[k].be[l]) begin
            o_data[8*l +: 8] = i_entry[k].data[8*l +: 8];
          end
        end
      end
    end
  end

  assign o_hit = |o_be;

endmodule

// File: rtl/store_buffer.sv
// Posted write buffer between the store formatter and the data-memory write
// port. Holds up to DEPTH stores in a circular FIFO and drains them in program
// order over a req/ack handshake. Optional feature macro: STORE_BUFFER_FWD_EN
// enables byte-granular forwarding of buffered data to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [AW-1:0]     st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [BE_W-1:0]   st_be,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [AW-1:0]     ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic [BE_W-1:0]   ld_be,
  output logic              empty,
  output logic              full
);

  localparam int            PW         = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);

  logic [AW-3:0] r_addr  [DEPTH];
  sb_payload_t   r_entry [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_unused_st_lo;

  // Occupancy decodes come straight from registered count, so full/empty and
  // st_ready never depend combinationally on st_valid or mem_ack.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_push  = st_valid && !w_full;
  assign w_pop   = !w_empty && mem_ack;

  assign w_unused_st_lo = ^st_addr[1:0];

  assign st_ready = !w_full;
  assign full     = w_full;
  assign empty    = w_empty;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (PW+1)'(1);
      end
    end
  end

  // Entry storage; contents only matter once counted as valid, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]        <= st_addr[AW-1:2];
      r_entry[r_wr_ptr].data  <= st_data;
      r_entry[r_wr_ptr].be    <= normalize_be(st_be);
    end
  end

  // Head entry drives the memory port; gating on empty zeroes it during and after reset
  assign mem_req   = !w_empty;
  assign mem_addr  = w_empty ? '0 : {r_addr[r_rd_ptr], 2'b00};
  assign mem_wdata = w_empty ? '0 : r_entry[r_rd_ptr].data;
  assign mem_be    = w_empty ? '0 : r_entry[r_rd_ptr].be;

`ifdef STORE_BUFFER_FWD_EN
  logic [AW-3:0]    w_age_addr  [DEPTH];
  sb_payload_t      w_age_entry [DEPTH];
  logic [DEPTH-1:0] w_age_valid;

  // Rotate storage so index 0 is the oldest entry and validity is a simple count compare
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_age_addr[k]  = r_addr[r_rd_ptr + PW'(k)];
      w_age_entry[k] = r_entry[r_rd_ptr + PW'(k)];
      w_age_valid[k] = ((PW+1)'(k) < r_count);
    end
  end

  store_buffer_fwd #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd (
    .i_addr    (w_age_addr),
    .i_entry   (w_age_entry),
    .i_valid   (w_age_valid),
    .i_ld_addr (ld_addr),
    .o_hit     (ld_hit),
    .o_data    (ld_data),
    .o_be      (ld_be)
  );
`else
  // Without forwarding the load path waits for empty before reading memory
  logic w_unused_ld;
  assign w_unused_ld = ^ld_addr;
  assign ld_hit      = 1'b0;
  assign ld_data     = '0;
  assign ld_be       = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, AW=32).
// Forwarding expectations follow STORE_BUFFER_FWD_EN.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;
  logic        empty;
  logic        full;

  int n_checks;
  int n_fail;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_be     (st_be),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .ld_be     (ld_be),
    .empty     (empty),
    .full      (full)
  );

  // Free-running 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_st_ready: got %b expected 1", st_ready); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin n_fail++; $display("[TB] FAIL reset_mem_outs: got %h expected 0", {mem_addr, mem_wdata, mem_be}); end
    n_checks++; if ({ld_hit, ld_data, ld_be} !== 37'h0) begin n_fail++; $display("[TB] FAIL reset_ld_outs: got %h expected 0", {ld_hit, ld_data, ld_be}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_ack_empty: got %b expected 1", empty); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ack_req: got %b expected 0", mem_req); end
    mem_ack = 1'b0;
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_after_ack_empty: got %b expected 1", empty); end
  endtask

  task automatic test_single_byte();
    push(32'h0000_1002, 32'h00AB_0000, 4'b0100);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL byte_req: got %b expected 1", mem_req); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("[TB] FAIL byte_addr[%0d]: got %h expected 00001000", i, mem_addr); end
      n_checks++; if (mem_be !== 4'b0100) begin n_fail++; $display("[TB] FAIL byte_be[%0d]: got %b expected 0100", i, mem_be); end
      n_checks++; if (mem_wdata !== 32'h00AB_0000) begin n_fail++; $display("[TB] FAIL byte_wdata[%0d]: got %h expected 00ab0000", i, mem_wdata); end
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL byte_drained_empty: got %b expected 1", empty); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL byte_drained_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_word_store();
    push(32'h0000_2000, 32'hDEAD_BEEF, 4'b0000);
    n_checks++; if (mem_be !== 4'b1111) begin n_fail++; $display("[TB] FAIL word_be: got %b expected 1111", mem_be); end
    n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL word_wdata: got %h expected deadbeef", mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL word_drained_empty: got %b expected 1", empty); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_ready[%0d]: got %b expected 1", i, st_ready); end
      push(32'h0000_0200 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'b1111);
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_not_ready: got %b expected 0", st_ready); end
    n_checks++; if (mem_addr !== 32'h0000_0200) begin n_fail++; $display("[TB] FAIL fill_head_addr: got %h expected 00000200", mem_addr); end
    // Fifth store offered while full with a same-cycle ack: must be refused
    mem_ack = 1'b1;
    push(32'h0000_02F0, 32'hBAD0_BAD0, 4'b1111);
    mem_ack = 1'b0;
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL refuse_count3_full: got %b expected 0", full); end
    n_checks++; if (mem_wdata !== 32'hA000_0001) begin n_fail++; $display("[TB] FAIL refuse_head: got %h expected a0000001", mem_wdata); end
    push(32'h0000_0210, 32'hA000_0004, 4'b1111);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_full_a: got %b expected 1", full); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (mem_wdata !== 32'hA000_0002) begin n_fail++; $display("[TB] FAIL wrap_head: got %h expected a0000002", mem_wdata); end
    push(32'h0000_0214, 32'hA000_0005, 4'b1111);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_full_b: got %b expected 1", full); end
    // Back-to-back acks retire one entry per cycle in issue order
    mem_ack = 1'b1;
    for (int j = 2; j < 6; j++) begin
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_req[%0d]: got %b expected 1", j, mem_req); end
      n_checks++; if (mem_wdata !== 32'hA000_0000 + 32'(j)) begin n_fail++; $display("[TB] FAIL drain_wdata[%0d]: got %h expected %h", j, mem_wdata, 32'hA000_0000 + 32'(j)); end
      n_checks++; if (mem_addr !== 32'h0000_0200 + 32'(4*j)) begin n_fail++; $display("[TB] FAIL drain_addr[%0d]: got %h expected %h", j, mem_addr, 32'h0000_0200 + 32'(4*j)); end
      tick();
    end
    mem_ack = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_forward();
    logic        exp_hit;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
`ifdef STORE_BUFFER_FWD_EN
    exp_hit  = 1'b1;
    exp_be   = 4'b0011;
    exp_data = 32'h0000_2233;
`else
    exp_hit  = 1'b0;
    exp_be   = 4'b0000;
    exp_data = 32'h0000_0000;
`endif
    ld_addr = 32'h0000_0103;
    #1;
    n_checks++; if (ld_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_empty_hit: got %b expected 0", ld_hit); end
    push(32'h0000_0100, 32'h0000_0011, 4'b0001);
    push(32'h0000_0100, 32'h0000_2200, 4'b0010);
    push(32'h0000_0100, 32'h0000_0033, 4'b0001);
    n_checks++; if (ld_hit !== exp_hit) begin n_fail++; $display("[TB] FAIL fwd_hit: got %b expected %b", ld_hit, exp_hit); end
    n_checks++; if (ld_be !== exp_be) begin n_fail++; $display("[TB] FAIL fwd_be: got %b expected %b", ld_be, exp_be); end
    n_checks++; if (ld_data !== exp_data) begin n_fail++; $display("[TB] FAIL fwd_data: got %h expected %h", ld_data, exp_data); end
    ld_addr = 32'h0000_0104;
    #1;
    n_checks++; if (ld_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_miss_hit: got %b expected 0", ld_hit); end
    n_checks++; if (ld_be !== 4'b0000) begin n_fail++; $display("[TB] FAIL fwd_miss_be: got %b expected 0000", ld_be); end
    // No coalescing: all three stores reach memory in order
    mem_ack = 1'b1;
    n_checks++; if (mem_wdata !== 32'h0000_0011) begin n_fail++; $display("[TB] FAIL fwd_drain0: got %h expected 00000011", mem_wdata); end
    tick();
    n_checks++; if (mem_wdata !== 32'h0000_2200) begin n_fail++; $display("[TB] FAIL fwd_drain1: got %h expected 00002200", mem_wdata); end
    tick();
    n_checks++; if (mem_wdata !== 32'h0000_0033) begin n_fail++; $display("[TB] FAIL fwd_drain2: got %h expected 00000033", mem_wdata); end
    tick();
    mem_ack = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fwd_drained_empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid_drain();
    push(32'h0000_0300, 32'h1111_1111, 4'b1111);
    push(32'h0000_0304, 32'h2222_2222, 4'b1111);
    push(32'h0000_0308, 32'h3333_3333, 4'b1111);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_req_before: got %b expected 1", mem_req); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_req_async: got %b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_addr_async: got %h expected 0", mem_addr); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_req_after[%0d]: got %b expected 0", i, mem_req); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_empty_after: got %b expected 1", empty); end
  endtask

  // Run each scenario in sequence, then report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_be    = '0;
    mem_ack  = 1'b0;
    ld_addr  = '0;
    test_reset();
    test_single_byte();
    test_word_store();
    test_fill_wrap();
    test_forward();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
